// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module mips_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              Div_Zero
);

    localparam int W     = DATA_W;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_mc;
    logic [2*W-1:0]   r_acc;

    logic             w_go;
    logic             w_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic             w_fast;
    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_step;
    logic [W:0]       w_rsh;
    logic [W+1:0]     w_diff;
    logic [2*W-1:0]   w_div_step;
    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_quo;
    logic [W-1:0]     w_rem;
    logic [W-1:0]     w_hi_res;
    logic [W-1:0]     w_lo_res;

    assign w_go    = Start && (r_state == S_IDLE) && !Op[2];
    assign w_sgn   = !Op[0];
    assign w_a_neg = w_sgn && A[W-1];
    assign w_b_neg = w_sgn && B[W-1];
    assign w_a_mag = w_a_neg ? (~A + 1'b1) : A;
    assign w_b_mag = w_b_neg ? (~B + 1'b1) : B;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] w_fast_prod;
    assign w_fast      = !Op[1];
    assign w_fast_prod = {{W{1'b0}}, w_a_mag} * {{W{1'b0}}, w_b_mag};
`else
    assign w_fast = 1'b0;
`endif

    // Shift-add: low half holds the remaining multiplier bits
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_mc};
    assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]}
                                 : {1'b0, r_acc[2*W-1:1]};

    // Restoring divide: shifted remainder needs W+1 bits for unsigned divisors
    assign w_rsh      = r_acc[2*W-1:W-1];
    assign w_diff     = {1'b0, w_rsh} - {2'b00, r_mc};
    assign w_div_step = w_diff[W+1] ? {w_rsh[W-1:0], r_acc[W-2:0], 1'b0}
                                    : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];

    always_comb begin
        w_hi_res = w_prod[2*W-1:W];
        w_lo_res = w_prod[W-1:0];
        if (Div_Zero) begin
            w_hi_res = r_a;
            w_lo_res = {W{1'b1}};
        end else if (r_div) begin
            w_hi_res = w_rem;
            w_lo_res = w_quo;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_go) w_next = w_fast ? S_FIX : S_ITER;
            S_ITER:  if (r_cnt == CNT_W'(W - 1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        if (r_state != S_IDLE) Busy = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_mc     <= '0;
            r_acc    <= '0;
            HI       <= '0;
            LO       <= '0;
            Done     <= 1'b0;
            Div_Zero <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cnt    <= '0;
                        r_div    <= Op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_a      <= A;
                        r_mc     <= Op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {{W{1'b0}}, Op[1] ? w_a_mag : w_b_mag};
                        Div_Zero <= Op[1] && (B == '0);
`ifdef MULDIV_FAST_MUL_EN
                        if (!Op[1]) r_acc <= w_fast_prod;
`endif
                    end else if (Start && Op == 3'b100) begin
                        HI <= A;
                    end else if (Start && Op == 3'b101) begin
                        LO <= A;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= r_div ? w_div_step : w_mul_step;
                end
                S_FIX: begin
                    HI   <= w_hi_res;
                    LO   <= w_lo_res;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
